ula_seq: RTL

ULA_SEQ -- requirements
Module: ula_seq

---
 rtl/ula_seq.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/ula_seq.sv
// Sequential ALU: single-cycle arithmetic/logic ops plus an iterative shift-add multiplier,
// with a valid/ready request side and a valid/ready result side.
module ula_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] outp,
    output logic [7:0]       flags
);

    localparam int unsigned SW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_NEG  = 4'b0010;
    localparam logic [3:0] OP_CMP  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_PASS = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_SHL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        HOLD
    } state_t;

    state_t                 state_q, state_d;
    logic [SW-1:0]          cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic [2*WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]       mplier_q, mplier_d;
    logic                   sign_q, sign_d;
    logic [WIDTH-1:0]       outp_q, outp_d;
    logic [7:0]             flags_q, flags_d;
    logic                   valid_q, valid_d;

    logic                   accept;
    logic                   complete;

    // Single-cycle datapath
    logic [WIDTH:0]         add_full;
    logic [WIDTH:0]         sub_full;
    logic [SW-1:0]          shamt;
    logic [WIDTH-1:0]       alu_res;
    logic [7:0]             alu_flags;
    logic                   c_err, c_lt, c_gt, c_eq, c_ovf, c_carry;

    // Multiplier datapath
    logic [WIDTH-1:0]       mag_a, mag_b;
    logic [2*WIDTH-1:0]     acc_step;
    logic [2*WIDTH-1:0]     prod;
    logic [WIDTH:0]         prod_hi;
    logic                   mul_ovf;
    logic [WIDTH-1:0]       mul_res;
    logic [7:0]             mul_flags;

    assign complete  = valid_q && out_ready;
    assign in_ready  = !rst && (state_q == IDLE) && (!valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = valid_q;
    assign outp      = outp_q;
    assign flags     = flags_q;

    always_comb begin
        add_full = {1'b0, a} + {1'b0, b};
        // Top bit of the widened difference is the unsigned borrow (a < b).
        sub_full = {1'b0, a} - {1'b0, b};
        shamt    = b[SW-1:0];
        alu_res  = '0;
        c_err    = 1'b0;
        c_lt     = 1'b0;
        c_gt     = 1'b0;
        c_eq     = 1'b0;
        c_ovf    = 1'b0;
        c_carry  = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = add_full[WIDTH-1:0];
                c_carry = add_full[WIDTH];
                c_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                alu_res = sub_full[WIDTH-1:0];
                c_carry = sub_full[WIDTH];
                c_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
                if (op == OP_CMP) begin
                    c_eq = (a == b);
                    c_lt = ($signed(a) < $signed(b));
                    c_gt = !c_eq && !c_lt;
                end
            end
            OP_NEG: begin
                alu_res = '0 - b;
                c_carry = |b;
                // Only the most-negative value negates to itself.
                c_ovf   = b[WIDTH-1] && alu_res[WIDTH-1];
            end
            OP_AND:  alu_res = a & b;
            OP_XOR:  alu_res = a ^ b;
            OP_OR:   alu_res = a | b;
            OP_PASS: alu_res = b;
            OP_MUL:  alu_res = '0;
            OP_SHL:  alu_res = a << shamt;
            OP_SRA:  alu_res = $signed(a) >>> shamt;
            default: c_err = 1'b1;
        endcase
        alu_flags = {c_err, c_lt, c_gt, c_eq, c_ovf, c_carry,
                     alu_res[WIDTH-1] & ~c_err, (alu_res == '0) & ~c_err};
    end

    always_comb begin
        mag_a    = a[WIDTH-1] ? ('0 - a) : a;
        mag_b    = b[WIDTH-1] ? ('0 - b) : b;
        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
        // The last iteration's sum feeds the sign fix-up directly so the result lands on that edge.
        prod     = sign_q ? ('0 - acc_step) : acc_step;
        prod_hi  = prod[2*WIDTH-1:WIDTH-1];
        mul_ovf  = !((&prod_hi) || !(|prod_hi));
        mul_res  = prod[WIDTH-1:0];
        mul_flags = {4'b0000, mul_ovf, 1'b0, mul_res[WIDTH-1], (mul_res == '0)};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        sign_d   = sign_q;
        outp_d   = outp_q;
        flags_d  = flags_q;
        valid_d  = valid_q;

        if (complete) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (op == OP_MUL) begin
                        state_d  = MUL;
                        cnt_d    = '0;
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, mag_a};
                        mplier_d = mag_b;
                        sign_d   = a[WIDTH-1] ^ b[WIDTH-1];
                        valid_d  = 1'b0;
                    end else begin
                        outp_d  = alu_res;
                        flags_d = alu_flags;
                        valid_d = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == SW'(WIDTH - 1)) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    outp_d  = mul_res;
                    flags_d = mul_flags;
                    valid_d = 1'b1;
                end
            end
            HOLD: begin
                if (complete) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            sign_q   <= 1'b0;
            outp_q   <= '0;
            flags_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            sign_q   <= sign_d;
            outp_q   <= outp_d;
            flags_q  <= flags_d;
            valid_q  <= valid_d;
        end
    end

endmodule
